// File: rtl/acumulador_somas.sv
// Collects a burst of N adder results over a valid/ready handshake and
// presents their running sum, modulo 2^ACC_W, with a sticky overflow flag.
module acumulador_somas #(
    parameter int WIDTH = 4,
    parameter int N     = 8,
    parameter int ACC_W = 6,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] soma,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] total,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state;
    logic [ACC_W:0]   sum;

    // One extra bit on the adder so the top bit is the carry-out of this beat
    assign sum = {1'b0, total} + (ACC_W + 1)'(soma);

    // Handshake outputs decode straight from state, so no input reaches them
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            total    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACC;
                        total    <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        total    <= sum[ACC_W-1:0];
                        overflow <= overflow | sum[ACC_W];
                        count    <= count + CNT_W'(1);
                        if (count == CNT_W'(N - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results are held here and kept in IDLE until the next start
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/acumulador_somas.md
Name: acumulador_somas

Overview:
- Downstream consumer of the 4-bit combinational adder (`somador`) output.
- Collects a burst of N `soma` results via a valid/ready handshake and accumulates them into a wider running total with a sticky overflow flag.
- Presents the final total on an output valid/ready handshake.
- Used as the result-collection stage behind the adder in lab exercises and benches.

Parameters:
- WIDTH, 4, width of each incoming `soma` word (matches the adder output width).
- N, 8, number of words accumulated per burst; legal range N >= 1.
- ACC_W, 6, width of the accumulator and of `total`; wraps modulo 2^ACC_W.
- CNT_W, $clog2(N+1), width of the `count` output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a new burst (honoured only in IDLE).
- soma  input  WIDTH  sum word from the adder stage.
- in_valid  input  1  `soma` is valid this cycle.
- in_ready  output  1  block accepts `soma` this cycle.
- total  output  ACC_W  accumulated sum modulo 2^ACC_W.
- count  output  CNT_W  number of words accepted in the current burst.
- overflow  output  1  sticky: some addition in this burst exceeded 2^ACC_W-1.
- busy  output  1  high in ACC and DONE.
- out_valid  output  1  final result available (DONE state).
- out_ready  input  1  consumer takes the result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, total=0, count=0, overflow=0, in_ready=0, out_valid=0, busy=0. Reset mid-burst discards all progress immediately.
- FSM states:
  - IDLE: in_ready=0, out_valid=0, busy=0. start=1 -> ACC; on that edge total<=0, count<=0, overflow<=0.
  - ACC: in_ready=1, busy=1. A beat is accepted when in_valid && in_ready; on acceptance:
    - total <= (total + zero-extended soma) mod 2^ACC_W.
    - overflow <= overflow | carry-out of that add.
    - count <= count+1.
    - If the accepted beat is the Nth (count==N-1 before the edge), next state is DONE.
    - in_valid=0 leaves all state unchanged; bubbles of any length are allowed.
  - DONE: in_ready=0, out_valid=1, busy=1. total, count (=N) and overflow are held stable. out_valid && out_ready -> IDLE. total, count and overflow keep their values in IDLE until the next start.
- Latency:
  - total and count reflect an accepted beat on the cycle after the acceptance edge.
  - out_valid rises on the cycle after the Nth acceptance.
  - Minimum burst from start to out_valid is N+1 cycles.
- Arithmetic: `soma` is treated as unsigned and zero-extended to ACC_W+1 bits; bit ACC_W of the sum is the carry.
- Boundary and ordering rules:
  - start while busy=1 is ignored (no clear, no restart).
  - in_valid while in IDLE or DONE is ignored; in_ready=0 there.
  - out_ready while not in DONE is ignored.
  - start and out_ready high in the same DONE cycle: return to IDLE only; start is not honoured in that cycle.
  - N=1: a single acceptance goes ACC->DONE.
  - total wraps without saturating; overflow stays 1 until the next start or reset.
- All outputs are registered or decoded purely from state; there is no combinational path from inputs to outputs.

Test Plan:
- Reset mid-burst: after 3 accepted words, pull rst_n low asynchronously -> total=0, count=0, overflow=0, in_ready=0, busy=0 immediately, without waiting for a clock edge.
- Nominal burst (N=8, ACC_W=6): feed the adder's wrapped outputs 1,5,14,15,0,0,0,1 back-to-back -> out_valid one cycle after the 8th beat, total=36, count=8, overflow=0.
- Overflow: 8 words of 15 -> total=56 (120 mod 64), overflow=1. Overflow stays 1 through DONE and after return to IDLE, and clears on the next start.
- Bubbles/backpressure: insert in_valid=0 gaps of 1-3 cycles between words, and hold out_ready=0 for 5 cycles in DONE -> total unchanged during gaps, and out_valid/total stable until out_ready=1. Return to IDLE one cycle after that.
- Ignored controls:
  - start pulsed during ACC -> no reset of total or count.
  - in_valid=1 with soma=7 in IDLE and in DONE -> total unchanged.
  - start together with out_ready in DONE -> ends in IDLE.
- N=1 variant: start, then one word soma=9 -> out_valid two cycles after start, total=9, count=1.
